// File: rtl/cpu_store_unit_pkg.sv
// Shared definitions for the store unit: funct3 store size codes and FSM state encoding.
package cpu_store_unit_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10
    } store_state_t;

endpackage

// File: rtl/cpu_store_unit_align.sv
// Combinational lane alignment: turns a store size, byte offset and register data
// into a 64-bit two-word data window, an 8-bit strobe window and error flags.
module cpu_store_align
    import cpu_store_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  control,
    input  logic [31:0] data,
    output logic [63:0] d64,
    output logic [7:0]  m8,
    output logic        straddle,
    output logic        illegal
);

    logic [31:0] masked;
    logic [3:0]  base;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        masked  = '0;
        base    = '0;
        illegal = 1'b0;
        case (control)
            F3_SB: begin masked = {24'b0, data[7:0]};  base = 4'b0001; end
            F3_SH: begin masked = {16'b0, data[15:0]}; base = 4'b0011; end
            F3_SW: begin masked = data;                base = 4'b1111; end
            default: illegal = 1'b1;
        endcase
    end

    assign d64      = {32'b0, masked} << {addr_lo, 3'b000};
    assign m8       = {4'b0, base} << addr_lo;
    assign straddle = |m8[7:4];

endmodule

// File: rtl/cpu_store_unit.sv
// Store unit: accepts one store request and issues it to the data-memory write port
// as one or two word-aligned beats with byte strobes.
module cpu_store_unit
    import cpu_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit SPLIT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        control,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              store_done,
    output logic              store_err
);

    store_state_t      state_q, state_d;
    logic              init_q;
    logic [63:0]       d64;
    logic [7:0]        m8;
    logic              straddle, illegal;
    logic [31:0]       b1_wdata_q;
    logic [3:0]        b1_wstrb_q;
    logic              need_b1_q;

    cpu_store_align u_align (
        .addr_lo  (addr[1:0]),
        .control  (control),
        .data     (wdata),
        .d64      (d64),
        .m8       (m8),
        .straddle (straddle),
        .illegal  (illegal)
    );

    logic accept, reject, handshake, final_hs;
    assign req_ready = (state_q == ST_IDLE) && init_q;
    assign mem_valid = (state_q != ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign reject    = illegal || (straddle && !SPLIT);
    assign handshake = mem_valid && mem_ready;
    assign final_hs  = handshake && ((state_q == ST_BEAT1) || !need_b1_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && !reject) state_d = ST_BEAT0;
            ST_BEAT0: if (mem_ready) state_d = need_b1_q ? ST_BEAT1 : ST_IDLE;
            ST_BEAT1: if (mem_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            b1_wdata_q <= '0;
            b1_wstrb_q <= '0;
            need_b1_q  <= 1'b0;
            store_done <= 1'b0;
            store_err  <= 1'b0;
        end else begin
            store_done <= final_hs;
            store_err  <= accept && reject;
            if (accept && !reject) begin
                mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
                mem_wdata  <= d64[31:0];
                mem_wstrb  <= m8[3:0];
                b1_wdata_q <= d64[63:32];
                b1_wstrb_q <= m8[7:4];
                need_b1_q  <= straddle;
            end else if (final_hs) begin
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_wstrb <= '0;
                need_b1_q <= 1'b0;
            end else if (handshake) begin
                // Second beat: next word, address wraps naturally at ADDR_W bits.
                mem_addr  <= mem_addr + ADDR_W'(4);
                mem_wdata <= b1_wdata_q;
                mem_wstrb <= b1_wstrb_q;
            end
        end
    end

endmodule

// File: tb/tb_cpu_store_unit.sv
// Directed self-checking bench for cpu_store_unit with hand-computed beat values.
module tb_cpu_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  control = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        store_done;
    logic        store_err;

    int checks = 0;
    int errors = 0;

    cpu_store_unit #(.ADDR_W(32), .SPLIT(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .addr       (addr),
        .wdata      (wdata),
        .control    (control),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .store_done (store_done),
        .store_err  (store_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        check({tag, " valid"}, 32'(mem_valid), 32'd1);
        check({tag, " addr"},  mem_addr, a);
        check({tag, " wdata"}, mem_wdata, d);
        check({tag, " wstrb"}, 32'(mem_wstrb), 32'(s));
        check({tag, " done"},  32'(store_done), 32'd0);
        check({tag, " ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        addr      = a;
        wdata     = d;
        control   = c;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic finish_check(input string tag);
        check({tag, " done"},   32'(store_done), 32'd1);
        check({tag, " rdy"},    32'(req_ready), 32'd1);
        check({tag, " novld"},  32'(mem_valid), 32'd0);
        step();
        check({tag, " done1"},  32'(store_done), 32'd0);
    endtask

    initial begin
        #3;
        check("rst valid", 32'(mem_valid), 32'd0);
        check("rst addr",  mem_addr, 32'd0);
        check("rst wdata", mem_wdata, 32'd0);
        check("rst wstrb", 32'(mem_wstrb), 32'd0);
        check("rst done",  32'(store_done), 32'd0);
        check("rst err",   32'(store_err), 32'd0);
        #10 rst_n = 1'b1;
        step();
        check("rst ready", 32'(req_ready), 32'd1);

        // sb to the top byte lane
        request(32'h103, 32'hAABBCCDD, 3'b000);
        beat("sb b0", 32'h100, 32'hDD000000, 4'b1000);
        step();
        finish_check("sb");

        // sh straddling a word boundary
        request(32'h103, 32'h1234CCDD, 3'b001);
        beat("sh b0", 32'h100, 32'hDD000000, 4'b1000);
        step();
        beat("sh b1", 32'h104, 32'h000000CC, 4'b0001);
        step();
        finish_check("sh");

        // sw straddling the top of the address space
        request(32'hFFFFFFFE, 32'h11223344, 3'b010);
        beat("sw b0", 32'hFFFFFFFC, 32'h33440000, 4'b1100);
        step();
        beat("sw b1", 32'h00000000, 32'h00001122, 4'b0011);
        step();
        finish_check("swrap");

        // aligned sw with memory back-pressure
        mem_ready = 1'b0;
        request(32'h200, 32'hCAFEF00D, 3'b010);
        for (int i = 0; i < 3; i++) begin
            beat("stall", 32'h200, 32'hCAFEF00D, 4'b1111);
            step();
        end
        mem_ready = 1'b1;
        beat("stall4", 32'h200, 32'hCAFEF00D, 4'b1111);
        step();
        finish_check("stall");

        // illegal size codes
        request(32'h300, 32'h12345678, 3'b011);
        check("ill3 err",   32'(store_err), 32'd1);
        check("ill3 valid", 32'(mem_valid), 32'd0);
        check("ill3 ready", 32'(req_ready), 32'd1);
        step();
        check("ill3 err1",  32'(store_err), 32'd0);
        check("ill3 vld1",  32'(mem_valid), 32'd0);
        request(32'h300, 32'h12345678, 3'b100);
        check("ill4 err",   32'(store_err), 32'd1);
        check("ill4 valid", 32'(mem_valid), 32'd0);
        check("ill4 ready", 32'(req_ready), 32'd1);
        step();
        check("ill4 done",  32'(store_done), 32'd0);

        // reset during the second beat of a split sh
        request(32'h103, 32'h1234CCDD, 3'b001);
        step();
        beat("rb b1", 32'h104, 32'h000000CC, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("rb async valid", 32'(mem_valid), 32'd0);
        step();
        check("rb done", 32'(store_done), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rb ready", 32'(req_ready), 32'd1);
        check("rb done2", 32'(store_done), 32'd0);
        request(32'h001, 32'h00000055, 3'b000);
        beat("post sb", 32'h000, 32'h00005500, 4'b0010);
        step();
        finish_check("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
